// File: rtl/arch_state.sv
// Architectural state for a Y86-style core: register file, condition codes, PC,
// sticky status and retired-instruction counter, all updated by one commit strobe.
module arch_state #(
  parameter int                DATA_W     = 64,
  parameter int                NREGS      = 15,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter int                INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              set_cc,
  input  logic [2:0]        cc_in,
  output logic [2:0]        cc,
  input  logic [DATA_W-1:0] new_pc,
  output logic [DATA_W-1:0] pc,
  input  logic [2:0]        stat_in,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [31:0]       retired
);

  // state | meaning
  // AOK   | running; commits are accepted
  // HLT   | halt instruction retired; frozen until reset
  // ADR   | bad address fault; frozen until reset
  // INS   | illegal instruction (or unknown status code); frozen until reset
  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } statT;

  statT              statQ;
  statT              statNext;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] pcQ;
  logic [2:0]        ccQ;
  logic [31:0]       retiredQ;
  logic              accept;
  logic              commitOk;

  assign accept   = commit && (statQ == AOK);
  assign commitOk = accept && (stat_in == 3'd1);

  always_ff @(posedge clk) begin
    if (reset) statQ <= AOK;
    else       statQ <= statNext;
  end

  always_comb begin
    statNext = statQ;
    if (accept && (stat_in != 3'd1)) begin
      case (stat_in)
        3'd2:    statNext = HLT;
        3'd3:    statNext = ADR;
        default: statNext = INS;
      endcase
    end
  end

  // Reads see pre-edge contents; out-of-range IDs (including RNONE) read zero.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == 4'(i)) valA = regs[i];
      if (srcB == 4'(i)) valB = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      pcQ      <= RESET_PC;
      ccQ      <= 3'b100;
      retiredQ <= '0;
    end else if (commitOk) begin
      // dstM is tested first so the memory result wins a same-register collision.
      for (int i = 0; i < NREGS; i++) begin
        if (dstM == 4'(i))      regs[i] <= valM;
        else if (dstE == 4'(i)) regs[i] <= valE;
      end
      if (set_cc) ccQ <= cc_in;
      pcQ      <= new_pc;
      retiredQ <= retiredQ + 32'd1;
    end
  end

  assign pc      = pcQ;
  assign cc      = ccQ;
  assign stat    = statQ;
  assign halted  = (statQ != AOK);
  assign retired = retiredQ;

endmodule

// File: tb/tb_arch_state.sv
// Bench for arch_state: directed vector table, a forced retired-counter wrap,
// then random commits compared against a behavioural model.
module tb_arch_state;

  logic        clk = 1'b0;
  logic        reset, commit, setCc;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, valE, valM, newPc, pc;
  logic [2:0]  ccIn, cc, statIn, stat;
  logic        halted;
  logic [31:0] retired;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  arch_state dut (
    .clk(clk), .reset(reset), .commit(commit),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .set_cc(setCc), .cc_in(ccIn), .cc(cc),
    .new_pc(newPc), .pc(pc),
    .stat_in(statIn), .stat(stat), .halted(halted), .retired(retired)
  );

  typedef struct {
    bit          rst;
    bit          cm;
    logic [3:0]  sA, sB, dE, dM;
    logic [63:0] vE, vM;
    bit          sc;
    logic [2:0]  ccI, stI;
    logic [63:0] npc;
    bit          chkRd;
    logic [63:0] eA, eB, ePc;
    logic [2:0]  eCc;
    logic [31:0] eRet;
    logic [2:0]  eSt;
  } vecT;

  vecT tbl [17];

  // behavioural model of the architectural state
  logic [63:0] mRegs [15];
  logic [63:0] mPc;
  logic [2:0]  mCc, mStat;
  logic [31:0] mRet;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mRead(input logic [3:0] id);
    return (id < 4'd15) ? mRegs[id] : 64'd0;
  endfunction

  task automatic mReset();
    for (int i = 0; i < 15; i++) mRegs[i] = 64'(i);
    mPc = 64'd0; mCc = 3'b100; mStat = 3'd1; mRet = 32'd0;
  endtask

  task automatic mEdge();
    if (reset) mReset();
    else if (commit && mStat == 3'd1) begin
      if (statIn == 3'd1) begin
        if (dstE < 4'd15) mRegs[dstE] = valE;
        if (dstM < 4'd15) mRegs[dstM] = valM;
        if (setCc) mCc = ccIn;
        mPc  = newPc;
        mRet = mRet + 32'd1;
      end else begin
        mStat = (statIn >= 3'd2 && statIn <= 3'd4) ? statIn : 3'd4;
      end
    end
  endtask

  task automatic drive(input vecT v);
    reset = v.rst; commit = v.cm; srcA = v.sA; srcB = v.sB;
    dstE = v.dE; dstM = v.dM; valE = v.vE; valM = v.vM;
    setCc = v.sc; ccIn = v.ccI; statIn = v.stI; newPc = v.npc;
  endtask

  // one model-checked cycle: reads before the edge, state after it
  task automatic step(input vecT v);
    drive(v);
    #1;
    if (mStat !== 3'bx) begin
      chk("rnd_valA", valA, mRead(srcA));
      chk("rnd_valB", valB, mRead(srcB));
    end
    @(posedge clk);
    mEdge();
    #1;
    chk("rnd_pc", pc, mPc);
    chk("rnd_cc", 64'(cc), 64'(mCc));
    chk("rnd_stat", 64'(stat), 64'(mStat));
    chk("rnd_halted", 64'(halted), 64'(mStat != 3'd1));
    chk("rnd_retired", 64'(retired), 64'(mRet));
  endtask

  function automatic vecT randVec(input int rstOdds);
    vecT v;
    v = '{default: '0};
    v.rst = ($urandom_range(rstOdds - 1, 0) == 0);
    v.cm  = $urandom_range(1, 0) == 1;
    v.sA  = 4'($urandom_range(15, 0));
    v.sB  = 4'($urandom_range(15, 0));
    v.dE  = 4'($urandom_range(15, 0));
    v.dM  = ($urandom_range(3, 0) == 0) ? v.dE : 4'($urandom_range(15, 0));
    v.vE  = {$urandom, $urandom};
    v.vM  = {$urandom, $urandom};
    v.sc  = $urandom_range(1, 0) == 1;
    v.ccI = 3'($urandom_range(7, 0));
    v.stI = ($urandom_range(11, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'd1;
    v.npc = {$urandom, $urandom};
    return v;
  endfunction

  initial begin
    vecT v;
    mStat = 3'bx;
    //            rst cm sA    sB    dE    dM    vE     vM     sc ccI   stI   npc    chk eA     eB     ePc    eCc   eRet eSt
    tbl[0]  = '{1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  0, 64'h0, 64'h0, 64'h0, 3'd4, 0, 3'd1};
    tbl[1]  = '{0, 0, 4'h3, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'h3, 64'h0, 64'h0, 3'd4, 0, 3'd1};
    tbl[2]  = '{0, 1, 4'h2, 4'h5, 4'h2, 4'h5, 64'hAA, 64'hBB, 0, 3'd0, 3'd1, 64'h0A, 1, 64'h2, 64'h5, 64'h0A, 3'd4, 1, 3'd1};
    tbl[3]  = '{0, 0, 4'h2, 4'h5, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'hAA, 64'hBB, 64'h0A, 3'd4, 1, 3'd1};
    tbl[4]  = '{0, 1, 4'h4, 4'h0, 4'h4, 4'h4, 64'h1, 64'h2, 1, 3'd2, 3'd1, 64'h14, 1, 64'h4, 64'h0, 64'h14, 3'd2, 2, 3'd1};
    tbl[5]  = '{0, 0, 4'h4, 4'h1, 4'h1, 4'hF, 64'h99, 64'h0, 1, 3'd7, 3'd1, 64'hFF, 1, 64'h2, 64'h1, 64'h14, 3'd2, 2, 3'd1};
    tbl[6]  = '{0, 0, 4'h1, 4'hE, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'h1, 64'hE, 64'h14, 3'd2, 2, 3'd1};
    tbl[7]  = '{0, 1, 4'h0, 4'hF, 4'hF, 4'hF, 64'h77, 64'h77, 0, 3'd0, 3'd1, 64'h18, 1, 64'h0, 64'h0, 64'h18, 3'd2, 3, 3'd1};
    tbl[8]  = '{0, 1, 4'h1, 4'h8, 4'h1, 4'hF, 64'h33, 64'h0, 1, 3'd1, 3'd2, 64'h99, 1, 64'h1, 64'h8, 64'h18, 3'd2, 3, 3'd2};
    tbl[9]  = '{0, 1, 4'h1, 4'h7, 4'h1, 4'h1, 64'h44, 64'h45, 1, 3'd1, 3'd1, 64'h50, 1, 64'h1, 64'h7, 64'h18, 3'd2, 3, 3'd2};
    tbl[10] = '{0, 0, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'h1, 64'hAA, 64'h18, 3'd2, 3, 3'd2};
    tbl[11] = '{1, 1, 4'h2, 4'h5, 4'h1, 4'hF, 64'h55, 64'h0, 1, 3'd1, 3'd1, 64'h70, 1, 64'hAA, 64'hBB, 64'h0, 3'd4, 0, 3'd1};
    tbl[12] = '{0, 0, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'h1, 64'h2, 64'h0, 3'd4, 0, 3'd1};
    tbl[13] = '{0, 1, 4'h3, 4'h5, 4'h3, 4'hF, 64'h1, 64'h0, 0, 3'd0, 3'd7, 64'h30, 1, 64'h3, 64'h5, 64'h0, 3'd4, 0, 3'd4};
    tbl[14] = '{0, 1, 4'h3, 4'h0, 4'h3, 4'hF, 64'h9, 64'h0, 0, 3'd0, 3'd1, 64'h40, 1, 64'h3, 64'h0, 64'h0, 3'd4, 0, 3'd4};
    tbl[15] = '{1, 0, 4'h3, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 3'd0, 3'd1, 64'h0,  1, 64'h3, 64'h0, 64'h0, 3'd4, 0, 3'd1};
    tbl[16] = '{0, 1, 4'h6, 4'hF, 4'h6, 4'hF, 64'h66, 64'h0, 0, 3'd0, 3'd1, 64'h8,  1, 64'h6, 64'h0, 64'h8, 3'd4, 1, 3'd1};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].chkRd) begin
        chk($sformatf("vec%0d_valA", i), valA, tbl[i].eA);
        chk($sformatf("vec%0d_valB", i), valB, tbl[i].eB);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].ePc);
      chk($sformatf("vec%0d_cc", i), 64'(cc), 64'(tbl[i].eCc));
      chk($sformatf("vec%0d_stat", i), 64'(stat), 64'(tbl[i].eSt));
      chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(tbl[i].eSt != 3'd1));
      chk($sformatf("vec%0d_retired", i), 64'(retired), 64'(tbl[i].eRet));
    end

    // retired wrap: force the counter near its top, then retire one instruction
    v = '{default: '0};
    v.rst = 1; v.dE = 4'hF; v.dM = 4'hF; v.stI = 3'd1;
    step(v);
    force dut.retiredQ = 32'hFFFF_FFFF;
    #1;
    release dut.retiredQ;
    #1;
    mRet = 32'hFFFF_FFFF;
    chk("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
    v.rst = 0; v.cm = 1; v.npc = 64'h100; v.dE = 4'h2; v.vE = 64'h1234;
    step(v);
    chk("wrap_zero", 64'(retired), 64'h0);
    v.cm = 0; v.dE = 4'h1; v.vE = 64'hDEAD; v.sA = 4'h1; v.sB = 4'h2;
    step(v);
    v.dE = 4'hF;
    step(v);
    chk("nocommit_r1", valA, 64'h1);
    chk("nocommit_r2", valB, 64'h1234);

    for (int i = 0; i < 400; i++) step(randVec(40));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/arch_state.md
ARCH_STATE -- requirements
Module: arch_state

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the width of every register, PC, valE and valM.
REQ-002 The block SHALL have parameter NREGS, default 15, giving the number of program registers; legal range 1..15; register IDs are 4 bits and ID 0xF is RNONE.
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded by reset.
REQ-004 The block SHALL have parameter INIT_INDEX, default 1; when 1, register i resets to value i, and when 0 every register resets to 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port commit, input, 1 bit: a one-cycle strobe that qualifies every architectural update for the current instruction.
REQ-008 The block SHALL have ports srcA and srcB, inputs, 4 bits each: read register IDs.
REQ-009 The block SHALL have ports valA and valB, outputs, DATA_W bits each: read data for srcA and srcB.
REQ-010 The block SHALL have ports dstE/valE and dstM/valM, inputs, 4 and DATA_W bits: the two write ports.
REQ-011 The block SHALL have ports set_cc (input, 1 bit) and cc_in (input, 3 bits, {ZF,SF,OF}): condition-code update request and value.
REQ-012 The block SHALL have port cc, output, 3 bits {ZF,SF,OF}: current condition codes.
REQ-013 The block SHALL have port new_pc, input, DATA_W bits, and port pc, output, DATA_W bits: next and current PC.
REQ-014 The block SHALL have port stat_in, input, 3 bits, and port stat, output, 3 bits, with encodings AOK=1, HLT=2, ADR=3, INS=4.
REQ-015 The block SHALL have port halted, output, 1 bit, asserted whenever stat != AOK.
REQ-016 The block SHALL have port retired, output, 32 bits: count of instructions committed with AOK status.

Function
REQ-017 Reads SHALL be combinational: valA and valB return the current register contents; any ID >= NREGS, including 0xF, SHALL read 0.
REQ-018 There SHALL be no write-to-read bypass: a read in the same cycle as a write returns the pre-edge value.
REQ-019 A commit SHALL be accepted on a rising edge only when commit=1, reset=0 and stat=AOK.
REQ-020 An accepted commit with stat_in=AOK SHALL write valE to dstE, write valM to dstM, load cc from cc_in if set_cc=1, load pc from new_pc, and increment retired.
REQ-021 A write SHALL be dropped when its destination ID is >= NREGS.
REQ-022 When dstE equals dstM and the ID is valid, valM SHALL win.
REQ-023 An accepted commit with stat_in != AOK SHALL only load stat from stat_in; register, CC and PC writes are suppressed and retired does not increment.
REQ-024 stat_in values outside 1..4 SHALL be captured as INS (4).
REQ-025 Once stat != AOK the state SHALL be frozen (sticky) until reset; commit pulses are ignored.
REQ-026 commit=0 SHALL leave all state unchanged regardless of the other inputs.
REQ-027 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 All writes from one accepted commit SHALL become visible together one cycle after the commit edge.

Reset
REQ-029 On a rising edge with reset=1 the block SHALL set pc=RESET_PC, cc=3'b100 (ZF=1), stat=AOK, halted=0, retired=0, and every register to its INIT_INDEX value.
REQ-030 Reset SHALL override a simultaneous commit, and a reset asserted while halted SHALL restore AOK.

Verification
REQ-031 Reset with INIT_INDEX=1, then read srcA=3, srcB=0xF -> valA=3, valB=0, pc=0, cc=100, stat=1, retired=0.
REQ-032 Commit with dstE=2/valE=0xAA and dstM=5/valM=0xBB, new_pc=0x0A -> next cycle r2=0xAA, r5=0xBB, pc=0x0A, retired=1.
REQ-033 Commit with dstE=dstM=4, valE=1, valM=2, set_cc=1, cc_in=010 -> r4=2, cc=010; same-cycle read of r4 shows the old value 4.
REQ-034 Commit with stat_in=HLT and dstE=1 -> stat=2, halted=1, r1 unchanged, pc unchanged; further commits ignored; then reset -> stat=1.
REQ-035 Preload retired to 0xFFFFFFFF via commits or force, then one AOK commit -> retired=0; commit=0 with dstE=1 -> no change.
REQ-036 Assert reset and commit (dstE=1, valE=0x55) together -> r1=1, retired=0; stat_in=7 commit -> stat=4.
